rtc_write_sequencer: RTL and testbench

Generates the write bus cycle for the RTC's multiplexed address/data bus: an address phase followed by a data phase, each with setup, strobe and hold intervals. It drives the write-side control set (AD_e, CS_e, RD_e, RW_e) into the RTC control multiplexer, which forwards it to the RTC pins when the read/write select is in write mode. It also drives the byte to place on the shared bus, plus the enable for the bus tri-state driver. All RTC control lines are active-low except AD (0 = address, 1 = data).

---
 rtl/rtc_write_sequencer_pkg.sv | 38 +++
 rtl/rtc_phase_cnt.sv | 42 ++++
 rtl/rtc_write_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_write_sequencer_pkg.sv
// Shared definitions for the RTC bus sequencers (write and readback).
// Holds the sequencer state encoding, default phase timings and the idle
// levels of the RTC control lines and data bus.
package rtc_write_sequencer_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASetup,
    StAStrobe,
    StAHold,
    StGap,
    StDSetup,
    StDStrobe,
    StDHold,
    StDone
  } rtc_wr_state_t;

  // Default phase lengths in clock cycles; every one must be >= 1.
  localparam int unsigned DefTSetup = 2;
  localparam int unsigned DefTPulse = 4;
  localparam int unsigned DefTHold  = 2;
  localparam int unsigned DefTGap   = 4;

  // Inactive level of AD/CS/RD/RW (all strobes active-low, AD=1 is data).
  localparam logic       LineIdle = 1'b1;
  localparam logic [7:0] BusIdle  = 8'h00;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_phase_cnt.sv
// Loadable down-counter timing each phase of an RTC bus cycle.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset, clears the count
//   load_i  - load value_i this cycle (takes priority over counting)
//   value_i - reload value (phase length minus one)
//   zero_o  - count is zero; the current phase ends on the next edge
// The count holds at zero instead of wrapping.
module rtc_phase_cnt #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_write_sequencer.sv
// Write bus-cycle generator for the RTC multiplexed address/data bus.
// One accepted start produces an address phase, a CS-high gap and a data
// phase, each phase being setup / strobe / hold, followed by one DONE cycle.
// Ports:
//   clk, reset_n      - clock and synchronous active-low reset
//   start, addr, data - write request; addr/data latched when start accepted in IDLE
//   busy, done        - sequence in flight / one-cycle completion pulse
//   AD_e, CS_e, RD_e, RW_e - write-side RTC control set to the control mux
//   dato_out, oe      - byte for the shared bus and its tri-state enable
// Every output is a flop loaded from the levels of the state being entered,
// so outputs change only on the edge that enters a state.
module rtc_write_sequencer
  import rtc_write_sequencer_pkg::*;
#(
  parameter int unsigned T_SETUP = DefTSetup,
  parameter int unsigned T_PULSE = DefTPulse,
  parameter int unsigned T_HOLD  = DefTHold,
  parameter int unsigned T_GAP   = DefTGap
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       AD_e,
  output logic       CS_e,
  output logic       RD_e,
  output logic       RW_e,
  output logic [7:0] dato_out,
  output logic       oe
);

  localparam int unsigned CntW = $clog2(max4(T_SETUP, T_PULSE, T_HOLD, T_GAP) + 1);

  rtc_wr_state_t   state_q, state_d;
  logic            accept;
  logic            cnt_load;
  logic [CntW-1:0] cnt_value;
  logic            cnt_zero;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;

  logic       ad_q, ad_d;
  logic       cs_q, cs_d;
  logic       rd_q;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic [7:0] dato_q, dato_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  rtc_phase_cnt #(
    .Width (CntW)
  ) u_phase_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .zero_o  (cnt_zero)
  );

  // State register and request latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next state: timed states advance once the phase counter has run down.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StASetup;
          accept  = 1'b1;
        end
      end
      StASetup:  if (cnt_zero) state_d = StAStrobe;
      StAStrobe: if (cnt_zero) state_d = StAHold;
      StAHold:   if (cnt_zero) state_d = StGap;
      StGap:     if (cnt_zero) state_d = StDSetup;
      StDSetup:  if (cnt_zero) state_d = StDStrobe;
      StDStrobe: if (cnt_zero) state_d = StDHold;
      StDHold:   if (cnt_zero) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Requests are only captured on acceptance; later input changes are ignored.
  always_comb begin
    addr_d = accept ? addr : addr_q;
    data_d = accept ? data : data_q;
  end

  // Counter reloads with (length - 1) of whichever state is being entered.
  always_comb begin
    cnt_load = (state_d != state_q);
    unique case (state_d)
      StASetup, StDSetup:   cnt_value = CntW'(T_SETUP - 1);
      StAStrobe, StDStrobe: cnt_value = CntW'(T_PULSE - 1);
      StAHold, StDHold:     cnt_value = CntW'(T_HOLD - 1);
      StGap:                cnt_value = CntW'(T_GAP - 1);
      default:              cnt_value = '0;
    endcase
  end

  // Output levels of the state being entered; addr_d/data_d make the latched
  // byte visible in the very first A_SETUP cycle.
  always_comb begin
    ad_d   = LineIdle;
    cs_d   = LineIdle;
    rw_d   = LineIdle;
    oe_d   = 1'b0;
    dato_d = BusIdle;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    unique case (state_d)
      StASetup, StAHold: begin
        ad_d   = 1'b0;
        cs_d   = 1'b0;
        oe_d   = 1'b1;
        dato_d = addr_d;
      end
      StAStrobe: begin
        ad_d   = 1'b0;
        cs_d   = 1'b0;
        rw_d   = 1'b0;
        oe_d   = 1'b1;
        dato_d = addr_d;
      end
      StDSetup, StDHold: begin
        cs_d   = 1'b0;
        oe_d   = 1'b1;
        dato_d = data_d;
      end
      StDStrobe: begin
        cs_d   = 1'b0;
        rw_d   = 1'b0;
        oe_d   = 1'b1;
        dato_d = data_d;
      end
      StIdle, StGap, StDone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ad_q   <= LineIdle;
      cs_q   <= LineIdle;
      rd_q   <= LineIdle;
      rw_q   <= LineIdle;
      oe_q   <= 1'b0;
      dato_q <= BusIdle;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ad_q   <= ad_d;
      cs_q   <= cs_d;
      rd_q   <= LineIdle;
      rw_q   <= rw_d;
      oe_q   <= oe_d;
      dato_q <= dato_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign AD_e     = ad_q;
  assign CS_e     = cs_q;
  assign RD_e     = rd_q;
  assign RW_e     = rw_q;
  assign oe       = oe_q;
  assign dato_out = dato_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: DUT 0 uses default timing, DUT 1 has every
// phase length set to 1. Each DUT is compared cycle by cycle against a model
// that derives the expected levels from the offset into the current write.
module tb_rtc_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn0 = 1'b0, st0 = 1'b0;
  logic [7:0] a0 = 8'h00, dt0 = 8'h00;
  logic       busy0, done0, ad0, cs0, rd0, rw0, oe0;
  logic [7:0] dato0;

  logic       rn1 = 1'b0, st1 = 1'b0;
  logic [7:0] a1 = 8'h00, dt1 = 8'h00;
  logic       busy1, done1, ad1, cs1, rd1, rw1, oe1;
  logic [7:0] dato1;

  rtc_write_sequencer dut0 (
    .clk(clk), .reset_n(rn0), .start(st0), .addr(a0), .data(dt0),
    .busy(busy0), .done(done0), .AD_e(ad0), .CS_e(cs0), .RD_e(rd0), .RW_e(rw0),
    .dato_out(dato0), .oe(oe0)
  );

  rtc_write_sequencer #(
    .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)
  ) dut1 (
    .clk(clk), .reset_n(rn1), .start(st1), .addr(a1), .data(dt1),
    .busy(busy1), .done(done1), .AD_e(ad1), .CS_e(cs1), .RD_e(rd1), .RW_e(rw1),
    .dato_out(dato1), .oe(oe1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int ts[2] = '{2, 1};
  int tp[2] = '{4, 1};
  int th[2] = '{2, 1};
  int tg[2] = '{4, 1};

  // Model: cycles of the current write still to go, and offset into it.
  int         rem[2] = '{0, 0};
  int         off[2] = '{0, 0};
  logic [7:0] ma[2];
  logic [7:0] md[2];
  bit         rst_hit[2];

  int edge_n = 0;
  int acc_edge[2] = '{0, 0};
  int busy_run[2] = '{0, 0};
  int rw_run[2]   = '{0, 0};
  int prev_done   = -1;
  bit b2b         = 1'b0;
  bit watch99     = 1'b0;
  bit seen99      = 1'b0;
  bit watch_done  = 1'b0;
  bit done_in_win = 1'b0;

  function automatic int total(input int d);
    return 2 * (ts[d] + tp[d] + th[d]) + tg[d] + 1;
  endfunction

  // {AD, CS, RD, RW, oe, dato[7:0], busy, done}
  function automatic logic [14:0] expv(input int d);
    int s, p, h, g, o, ph;
    logic [7:0] v;
    logic ad;
    if (rem[d] == 0) return {4'b1111, 1'b0, 8'h00, 2'b00};
    s  = ts[d];
    p  = tp[d];
    h  = th[d];
    g  = tg[d];
    o  = off[d];
    ph = s + p + h;
    if (o < ph) begin
      ad = 1'b0;
      v  = ma[d];
    end else if (o < ph + g) begin
      return {4'b1111, 1'b0, 8'h00, 2'b10};
    end else if (o < 2 * ph + g) begin
      ad = 1'b1;
      v  = md[d];
      o  = o - ph - g;
    end else begin
      return {4'b1111, 1'b0, 8'h00, 2'b11};
    end
    return {ad, 1'b0, 1'b1, (o >= s && o < s + p) ? 1'b0 : 1'b1, 1'b1, v, 2'b10};
  endfunction

  task automatic chk_vec(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_update(input int d, input logic rn, input logic st,
                              input logic [7:0] a, input logic [7:0] dv);
    rst_hit[d] = 1'b0;
    if (!rn) begin
      rem[d]     = 0;
      rst_hit[d] = 1'b1;
    end else if (rem[d] == 0) begin
      if (st) begin
        rem[d]      = total(d);
        off[d]      = 0;
        ma[d]       = a;
        md[d]       = dv;
        acc_edge[d] = edge_n + 1;
      end
    end else begin
      rem[d]--;
      off[d]++;
    end
  endtask

  task automatic observe(input int d, input logic [14:0] obs);
    chk_vec(d == 0 ? "cycle_dut0" : "cycle_dut1", obs, expv(d));
    if (rst_hit[d]) begin
      busy_run[d] = 0;
      rw_run[d]   = 0;
      return;
    end
    if (obs[1]) busy_run[d]++;
    if (obs[0]) begin
      chk_int("busy_length", busy_run[d], total(d));
      chk_int("done_latency", edge_n - acc_edge[d], total(d) - 1);
      busy_run[d] = 0;
      if (d == 0 && b2b) begin
        if (prev_done >= 0) chk_int("b2b_done_gap", edge_n - prev_done, total(0) + 1);
        prev_done = edge_n;
      end
    end
    if (!obs[11]) begin
      rw_run[d]++;
    end else if (rw_run[d] > 0) begin
      chk_int("rw_width", rw_run[d], tp[d]);
      rw_run[d] = 0;
    end
    if (d == 0 && watch99 && obs[9:2] == 8'h99) seen99 = 1'b1;
    if (d == 0 && watch_done && obs[0]) done_in_win = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0, rn0, st0, a0, dt0);
    model_update(1, rn1, st1, a1, dt1);
    #1;
    edge_n++;
    observe(0, {ad0, cs0, rd0, rw0, oe0, dato0, busy0, done0});
    observe(1, {ad1, cs1, rd1, rw1, oe1, dato1, busy1, done1});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset, then a long idle stretch.
    steps(3);
    rn0 = 1'b1;
    rn1 = 1'b1;
    steps(20);

    // Single write.
    a0 = 8'h21; dt0 = 8'h45; st0 = 1'b1;
    step();
    st0 = 1'b0;
    steps(25);

    // Start while busy must be dropped, not queued.
    watch99 = 1'b1;
    a0 = 8'h21; dt0 = 8'h45; st0 = 1'b1;
    step();
    st0 = 1'b0;
    steps(4);
    a0 = 8'h99; dt0 = 8'h99; st0 = 1'b1;
    step();
    st0 = 1'b0;
    steps(25);
    watch99 = 1'b0;
    chk_int("ignored_start_addr_seen", int'(seen99), 0);

    // Back-to-back with start held high and inputs churning.
    b2b = 1'b1;
    st0 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a0  = 8'($urandom);
      dt0 = 8'($urandom);
      step();
    end
    st0 = 1'b0;
    b2b = 1'b0;
    steps(25);

    // Reset in the middle of the address strobe.
    a0 = 8'h5A; dt0 = 8'hA5; st0 = 1'b1;
    step();
    st0 = 1'b0;
    steps(3);
    chk_int("pre_reset_rw_low", int'(rw0), 0);
    rn0 = 1'b0;
    step();
    chk_int("rst_cs_idle", int'(cs0), 1);
    chk_int("rst_rw_idle", int'(rw0), 1);
    chk_int("rst_oe_off", int'(oe0), 0);
    rn0 = 1'b1;
    watch_done = 1'b1;
    steps(30);
    watch_done = 1'b0;
    chk_int("no_done_after_reset", int'(done_in_win), 0);

    // Random writes with random gaps and stray starts while busy.
    for (int n = 0; n < 8; n++) begin
      a0  = 8'($urandom);
      dt0 = 8'($urandom);
      st0 = 1'b1;
      step();
      for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
        st0 = ($urandom_range(0, 3) == 0);
        a0  = 8'($urandom);
        dt0 = 8'($urandom);
        step();
      end
      st0 = 1'b0;
    end
    steps(25);

    // Minimum timing on DUT 1: isolated writes, then back-to-back.
    for (int n = 0; n < 4; n++) begin
      a1  = 8'($urandom);
      dt1 = 8'($urandom);
      st1 = 1'b1;
      step();
      st1 = 1'b0;
      steps(int'($urandom_range(8, 12)));
    end
    st1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a1  = 8'($urandom);
      dt1 = 8'($urandom);
      step();
    end
    st1 = 1'b0;
    steps(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
